// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS fetch path.
//   fetch_state_t    : fetch sequencer states
//   PC_* constants   : PCSelector encodings from the control decoder
//   *_MSB/*_LSB      : instruction field positions (opcode, funct, imm16, index26)
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int FUNCT_MSB   = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int IMM16_MSB   = 15;
  localparam int IMM16_LSB   = 0;
  localparam int INDEX26_MSB = 25;
  localparam int INDEX26_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: purely combinational next-PC computation.
// Ports:
//   pc             in  32  address of the instruction being issued
//   index26        in  26  Instruction[25:0]; imm16 is its low half
//   pc_selector    in  2   PC_SEQ / PC_BRANCH / PC_REG / PC_JUMP
//   jump_reg_value in  32  rs value for jr
//   pc_plus4       out 32  pc + 4 (also the jal link address)
//   next_pc        out 32  selected target
//   misaligned     out 1   target is not word-aligned
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]                  pc,
  input  logic [INDEX26_MSB:INDEX26_LSB] index26,
  input  logic [1:0]                   pc_selector,
  input  logic [31:0]                  jump_reg_value,
  output logic [31:0]                  pc_plus4,
  output logic [31:0]                  next_pc,
  output logic                         misaligned
);

  logic [15:0] imm16;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;

  // The immediate field occupies the low half of the 26-bit index field.
  assign imm16         = index26[IMM16_MSB:IMM16_LSB];
  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_target   = {pc_plus4[31:28], index26, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_selector)
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + branch_offset;
      PC_REG:    next_pc = jump_reg_value;
      PC_JUMP:   next_pc = jump_target;
      default:   next_pc = pc_plus4;
    endcase
  end

  // Only the register target can actually be misaligned; the others are
  // aligned by construction.
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Ports:
//   Clock, Reset          single rising-edge clock, synchronous active-high reset
//   InstrReq/InstrAddr    fetch request and address (address is the PC)
//   InstrAck/InstrData    memory response, accepted only while fetching
//   Instruction           latched instruction word
//   Operator/Func         opcode and funct fields of Instruction
//   IssueValid/IssueReady issue handshake with the execute stage
//   PCSelector            next-PC source, sampled on issue transfer
//   JumpRegValue          jr target, sampled on issue transfer
//   PC/LinkAddress        current instruction address and PC + 4
//   Fault                 sticky misaligned-target fault, cleared only by Reset
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic        InstrAck,
  input  logic [31:0] InstrData,
  output logic [31:0] Instruction,
  output logic [5:0]  Operator,
  output logic [5:0]  Func,
  output logic        IssueValid,
  input  logic        IssueReady,
  input  logic [1:0]  PCSelector,
  input  logic [31:0] JumpRegValue,
  output logic [31:0] PC,
  output logic [31:0] LinkAddress,
  output logic        Fault
);

  fetch_state_t state, next_state;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         load_instr;
  logic         load_pc;

  next_pc_calc u_next_pc_calc (
    .pc             (pc_q),
    .index26        (instr_q[INDEX26_MSB:INDEX26_LSB]),
    .pc_selector    (PCSelector),
    .jump_reg_value (JumpRegValue),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .misaligned     (misaligned)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state <= next_state;
      if (load_instr) instr_q <= InstrData;
      if (load_pc)    pc_q    <= next_pc;
    end
  end

  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    InstrReq   = 1'b0;
    IssueValid = 1'b0;
    unique case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        InstrReq = 1'b1;
        if (InstrAck) begin
          load_instr = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        IssueValid = 1'b1;
        // A misaligned target parks the unit in FAULT with the PC still
        // pointing at the offending instruction.
        if (IssueReady) begin
          if (misaligned) begin
            next_state = FAULT;
          end else begin
            load_pc    = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FAULT: next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  assign InstrAddr   = pc_q;
  assign PC          = pc_q;
  assign LinkAddress = pc_plus4;
  assign Instruction = instr_q;
  assign Operator    = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign Func        = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign Fault       = (state == FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: self-checking bench for pc_fetch_unit.
// A behavioural model tracks PC, Instruction and the fetch/issue phase from
// the observed inputs; a compare process checks every output on every
// falling edge, and the directed sequence pins key values with literals.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clock;
  logic        Reset;
  logic        InstrReq;
  logic [31:0] InstrAddr;
  logic        InstrAck;
  logic [31:0] InstrData;
  logic [31:0] Instruction;
  logic [5:0]  Operator;
  logic [5:0]  Func;
  logic        IssueValid;
  logic        IssueReady;
  logic [1:0]  PCSelector;
  logic [31:0] JumpRegValue;
  logic [31:0] PC;
  logic [31:0] LinkAddress;
  logic        Fault;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .InstrReq     (InstrReq),
    .InstrAddr    (InstrAddr),
    .InstrAck     (InstrAck),
    .InstrData    (InstrData),
    .Instruction  (Instruction),
    .Operator     (Operator),
    .Func         (Func),
    .IssueValid   (IssueValid),
    .IssueReady   (IssueReady),
    .PCSelector   (PCSelector),
    .JumpRegValue (JumpRegValue),
    .PC           (PC),
    .LinkAddress  (LinkAddress),
    .Fault        (Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model of the fetch sequencer.
  typedef enum int {M_STARTING, M_AWAIT_MEMORY, M_OFFERING, M_STOPPED} model_phase_t;
  model_phase_t m_phase = M_STARTING;
  logic [31:0]  m_pc    = 32'h0;
  logic [31:0]  m_instr = 32'h0;
  bit           m_valid = 1'b0;

  function automatic logic [31:0] targetOf(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic [1:0] sel, input logic [31:0] jr);
    logic [31:0]        seq;
    logic signed [31:0] off;
    seq = pc + 32'd4;
    off = $signed(instr[15:0]);
    case (sel)
      2'd0:    return seq;
      2'd1:    return seq + 32'(off * 4);
      2'd2:    return jr;
      default: return (seq & 32'hF000_0000) | (32'(instr[25:0]) << 2);
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase = M_STARTING;
      m_pc    = RESET_PC;
      m_instr = 32'h0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        M_STARTING: m_phase = M_AWAIT_MEMORY;
        M_AWAIT_MEMORY: if (InstrAck) begin
          m_instr = InstrData;
          m_phase = M_OFFERING;
        end
        M_OFFERING: if (IssueReady) begin
          logic [31:0] t;
          t = targetOf(m_pc, m_instr, PCSelector, JumpRegValue);
          if (t % 4 != 0) m_phase = M_STOPPED;
          else begin
            m_pc    = t;
            m_phase = M_AWAIT_MEMORY;
          end
        end
        default: m_phase = M_STOPPED;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      checkOutput("InstrReq",    32'(InstrReq),    32'(m_phase == M_AWAIT_MEMORY));
      checkOutput("IssueValid",  32'(IssueValid),  32'(m_phase == M_OFFERING));
      checkOutput("Fault",       32'(Fault),       32'(m_phase == M_STOPPED));
      checkOutput("InstrAddr",   InstrAddr,        m_pc);
      checkOutput("PC",          PC,               m_pc);
      checkOutput("LinkAddress", LinkAddress,      m_pc + 32'd4);
      checkOutput("Instruction", Instruction,      m_instr);
      checkOutput("Operator",    32'(Operator),    m_instr >> 26);
      checkOutput("Func",        32'(Func),        m_instr & 32'h3F);
    end
  end

  task automatic stepCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic ready,
                               input logic [1:0] sel, input logic [31:0] jr);
    InstrAck     = ack;
    InstrData    = data;
    IssueReady   = ready;
    PCSelector   = sel;
    JumpRegValue = jr;
  endtask

  task automatic waitFor(input string what, input bit want_req);
    int n;
    n = 0;
    while (!(want_req ? InstrReq : IssueValid) && n < 16) begin
      stepCycle();
      n++;
    end
    checkOutput({"wait ", what}, 32'(want_req ? InstrReq : IssueValid), 32'd1);
  endtask

  task automatic fetchWord(input logic [31:0] word, input int delay);
    waitFor("fetch request", 1'b1);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, PC_SEQ, 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, word, 1'b0, PC_SEQ, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, PC_SEQ, 32'h0);
  endtask

  // Stall cycles also drive stray acks and toggling selectors, all of which
  // must be ignored while the issue is pending.
  task automatic issueWith(input logic [1:0] sel, input logic [31:0] jr, input int stall);
    waitFor("issue valid", 1'b0);
    for (int i = 0; i < stall; i++) begin
      applyStimulus(1'b1, 32'hBAD0_0000 | 32'(i), 1'b0, 2'(i), 32'h3);
      stepCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, sel, jr);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, PC_SEQ, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, PC_SEQ, 32'h0);
    repeat (2) stepCycle();
    checkOutput("reset PC", PC, 32'h0);
    checkOutput("reset Instruction", Instruction, 32'h0);
    checkOutput("reset LinkAddress", LinkAddress, 32'h4);
    checkOutput("reset InstrReq", 32'(InstrReq), 32'h0);
    checkOutput("reset IssueValid", 32'(IssueValid), 32'h0);
    checkOutput("reset Fault", 32'(Fault), 32'h0);
    Reset = 1'b0;
    stepCycle();
    checkOutput("first fetch req", 32'(InstrReq), 32'h1);
    checkOutput("first fetch addr", InstrAddr, 32'h0);

    fetchWord(32'h2008_0005, 0);
    checkOutput("issue after ack", 32'(IssueValid), 32'h1);
    checkOutput("req drops after ack", 32'(InstrReq), 32'h0);
    checkOutput("addi opcode", 32'(Operator), 32'h08);
    issueWith(PC_SEQ, 32'h0, 0);
    checkOutput("sequential addr", InstrAddr, 32'h4);

    fetchWord(32'h0800_0010, 0);
    issueWith(PC_JUMP, 32'h0, 0);
    checkOutput("jump to 0x40", InstrAddr, 32'h40);

    fetchWord(32'h1000_FFFE, 0);
    issueWith(PC_BRANCH, 32'h0, 0);
    checkOutput("branch back", InstrAddr, 32'h3C);

    fetchWord(32'h0000_0020, 0);
    checkOutput("add funct", 32'(Func), 32'h20);
    issueWith(PC_SEQ, 32'h0, 0);
    fetchWord(32'h1000_0003, 0);
    issueWith(PC_BRANCH, 32'h0, 0);
    checkOutput("branch forward", InstrAddr, 32'h50);

    fetchWord(32'h0060_0008, 0);
    issueWith(PC_REG, 32'h1000_0010, 0);
    checkOutput("jr aligned", InstrAddr, 32'h1000_0010);

    fetchWord(32'h0C00_0100, 3);
    checkOutput("jal link", LinkAddress, 32'h1000_0014);
    checkOutput("jal opcode", 32'(Operator), 32'h03);
    issueWith(PC_JUMP, 32'h0, 4);
    checkOutput("jal target", InstrAddr, 32'h1000_0400);

    fetchWord(32'h0000_0008, 0);
    issueWith(PC_REG, 32'hFFFF_FFFC, 0);
    checkOutput("top of memory", InstrAddr, 32'hFFFF_FFFC);
    fetchWord(32'h0000_0020, 1);
    issueWith(PC_SEQ, 32'h0, 0);
    checkOutput("wrap addr", InstrAddr, 32'h0);
    checkOutput("wrap no fault", 32'(Fault), 32'h0);

    applyStimulus(1'b0, 32'h0, 1'b0, PC_SEQ, 32'h0);
    stepCycle();
    Reset = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, PC_JUMP, 32'h0);
    stepCycle();
    Reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, PC_SEQ, 32'h0);
    checkOutput("reset mid-fetch req", 32'(InstrReq), 32'h0);
    checkOutput("reset mid-fetch instr", Instruction, 32'h0);
    stepCycle();
    checkOutput("refetch req", 32'(InstrReq), 32'h1);
    checkOutput("refetch addr", InstrAddr, RESET_PC);

    fetchWord(32'h0040_0008, 0);
    issueWith(PC_REG, 32'h0000_0102, 0);
    checkOutput("misaligned fault", 32'(Fault), 32'h1);
    checkOutput("fault keeps PC", PC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, PC_SEQ, 32'h0);
      stepCycle();
      checkOutput("fault sticky", 32'(Fault), 32'h1);
      checkOutput("fault no req", 32'(InstrReq), 32'h0);
      checkOutput("fault no issue", 32'(IssueValid), 32'h0);
    end
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, PC_SEQ, 32'h0);
    stepCycle();
    Reset = 1'b0;
    checkOutput("fault cleared", 32'(Fault), 32'h0);
    checkOutput("restart PC", PC, RESET_PC);
    fetchWord(32'h2008_0005, 0);
    issueWith(PC_SEQ, 32'h0, 0);
    checkOutput("restart sequential", InstrAddr, 32'h4);

    repeat (2) stepCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
